// File: rtl/cla_adder_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : cla_adder_pipelined
// Brief    : Pipelined carry-lookahead adder/subtractor with valid/ready flow
//            control; one CHUNK resolved per stage. Optional saturation via
//            macro CLA_ADDER_SATURATE_EN.
// Revision : 1.0
// ============================================================================
module cla_adder_pipelined #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;

  // Stage k: valid, carry into chunk k, operands (b pre-inverted), chunks 0..k-1 of the result
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];

  logic             w_load  [STAGES];
  logic             w_cout  [STAGES];
  logic [WIDTH-1:0] w_spass [STAGES];
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] b_d;
  logic             c_d;

  function automatic logic [CHUNK:0] cla_chunk(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             ci
  );
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] s;
    logic             gg;
    logic             pp;
    g  = x & y;
    p  = x ^ y;
    s  = '0;
    gg = 1'b0;
    pp = 1'b1;
    // Each bit's carry is formed from the group generate/propagate and ci directly
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = p[i] ^ (gg | (pp & ci));
      gg   = g[i] | (p[i] & gg);
      pp   = p[i] & pp;
    end
    return {gg | (pp & ci), s};
  endfunction

  always_comb begin : p_chunks
    logic [CHUNK:0] r;
    r = '0;
    for (int k = 0; k < STAGES; k++) begin
      r                            = cla_chunk(a_q[k][k*CHUNK +: CHUNK],
                                               b_q[k][k*CHUNK +: CHUNK], c_q[k]);
      w_cout[k]                    = r[CHUNK];
      w_spass[k]                   = s_q[k];
      w_spass[k][k*CHUNK +: CHUNK] = r[CHUNK-1:0];
    end
  end

  // A stage may load when empty or when everything downstream can drain
  always_comb begin : p_load
    logic ld;
    ld = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld        = ~v_q[k] | ld;
      w_load[k] = ld;
    end
  end

  assign b_d      = sub ? ~b : b;
  assign c_d      = sub | cin;
  assign in_ready = w_load[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          a_q[0] <= a;
          b_q[0] <= b_d;
          c_q[0] <= c_d;
          s_q[0] <= '0;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
            c_q[k] <= w_cout[k-1];
            s_q[k] <= w_spass[k-1];
          end
        end
      end
    end
  end

  assign w_raw     = w_spass[STAGES-1];
  assign out_valid = v_q[STAGES-1];
  assign cout      = w_cout[STAGES-1];
  assign ovf       = (a_q[STAGES-1][MSB] == b_q[STAGES-1][MSB]) &&
                     (w_raw[MSB] != a_q[STAGES-1][MSB]);

`ifdef CLA_ADDER_SATURATE_EN
  logic [WIDTH-1:0] w_limit;
  assign w_limit = a_q[STAGES-1][MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
  assign sum     = ovf ? w_limit : w_raw;
`else
  assign sum     = w_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_adder_pipelined
// Brief    : Directed self-checking bench for the 64-bit/4-stage and the
//            16-bit/1-stage configurations of cla_adder_pipelined.
// Revision : 1.0
// ============================================================================
module tb_cla_adder_pipelined;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [63:0] a, b, sum;
  logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
  logic [15:0] a2, b2, sum2;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  cla_adder_pipelined #(.WIDTH(64), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_adder_pipelined #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single beat with out_ready high; called and returns one step after a rising edge
  task automatic run1(input string tag, input logic [63:0] av, input logic [63:0] bv,
                      input logic ci, input logic sb, input logic [63:0] es,
                      input logic ec, input logic eo);
    int lat;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    int sent, recv, stale;
    bit stall_seen;
    rst_n = 1'b1;
    in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 1;
    in_valid2 = 0; a2 = '0; b2 = '0; cin2 = 0; sub2 = 0; out_ready2 = 1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst1_out_valid", out_valid2, 0);
    chk("rst1_sum", sum2, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    run1("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h0, 1, 0);
    run1("sub_borrow", 64'd5, 64'd7, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    run1("sub_pos", 64'd7, 64'd5, 0, 1, 64'd2, 1, 0);
    run1("sub_cin_ignored", 64'd10, 64'd3, 1, 1, 64'd7, 1, 0);
    run1("cin_chain", 64'h0000_0000_FFFF_FFFF, 64'h0, 1, 0, 64'h0000_0001_0000_0000, 0, 0);
`ifdef CLA_ADDER_SATURATE_EN
    run1("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1);
    run1("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0,
         64'h8000_0000_0000_0000, 1, 1);
    run1("ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 0, 1, 64'h8000_0000_0000_0000, 1, 1);
`else
    run1("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h8000_0000_0000_0000, 0, 1);
    run1("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 64'h0, 1, 1);
    run1("ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1);
`endif

    // Streaming with a stall window on cycles 6..15
    sent = 0; recv = 0; stall_seen = 0;
    for (int cyc = 0; cyc < 100 && recv < 16; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 15);
      in_valid  = (sent < 16);
      a = 64'(sent); b = 64'(3 * sent); cin = 0; sub = 0;
      #1;
      if (!in_ready && !stall_seen) begin
        chk("stream_full_occupancy", 64'(sent - recv), 4);
        stall_seen = 1;
      end
      if (out_valid) chk("stream_sum", sum, 64'(4 * recv));
      if (out_valid && out_ready) recv++;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    chk("stream_stall_seen", 64'(stall_seen), 1);
    chk("stream_recv_count", 64'(recv), 16);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    chk("stream_no_dup", 64'(stale), 0);

    // Reset with three beats in flight, head beat stalled at the output
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; a = 64'(100 + i); b = 64'h0; cin = 0; sub = 0;
      #1;
      chk("rst_mid_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(posedge clk); #1;
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_sum", sum, 64'd100);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1; out_ready = 1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    chk("post_rst_no_stale", 64'(stale), 0);
    run1("post_rst", 64'd9, 64'd6, 0, 0, 64'd15, 0, 0);

    // Single-stage 16-bit instance
    a2 = 16'h8000; b2 = 16'h8000; cin2 = 0; sub2 = 0; in_valid2 = 1; out_ready2 = 0;
    #1;
    chk("s1_in_ready", in_ready2, 1);
    @(posedge clk); #1;
    in_valid2 = 0;
    chk("s1_out_valid", out_valid2, 1);
`ifdef CLA_ADDER_SATURATE_EN
    chk("s1_sum", sum2, 16'h8000);
`else
    chk("s1_sum", sum2, 16'h0000);
`endif
    chk("s1_cout", cout2, 1);
    chk("s1_ovf", ovf2, 1);
    @(posedge clk); #1;
    chk("s1_hold_valid", out_valid2, 1);
    chk("s1_hold_in_ready", in_ready2, 0);
    chk("s1_hold_cout", cout2, 1);
    out_ready2 = 1;
    a2 = 16'h0003; b2 = 16'h0005; sub2 = 1; in_valid2 = 1;
    #1;
    chk("s1_pass_in_ready", in_ready2, 1);
    @(posedge clk); #1;
    in_valid2 = 0;
    chk("s1_sub_valid", out_valid2, 1);
    chk("s1_sub_sum", sum2, 16'hFFFE);
    chk("s1_sub_cout", cout2, 0);
    chk("s1_sub_ovf", ovf2, 0);
    @(posedge clk); #1;
    chk("s1_drained", out_valid2, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_adder_pipelined.md
Name: cla_adder_pipelined

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed-width cascaded CLA: operand width and pipeline depth are parameters, it adds a subtract mode and signed-overflow flag, and uses a valid/ready handshake with per-stage back-pressure. It sits between operand-producing datapath blocks and result consumers, and allows wide adds at high clock rates.

Parameters:
WIDTH, 64, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline stages; each stage resolves one WIDTH/STAGES-bit chunk (CHUNK) with internal CLA logic; legal 1..WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in, used only when sub=0
sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB; in sub mode 1 = no borrow
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: one clock, asynchronous active-low reset as above. While rst_n=0, all stage valid bits are 0, out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 after release. Reset mid-operation discards all in-flight beats; there is no partial output.
- Transfers: input handshake when in_valid&&in_ready; output handshake when out_valid&&out_ready. sum/cout/ovf hold stable while out_valid=1 and out_ready=0.
- Stage k (0..STAGES-1) holds v[k], the carry into chunk k, result chunks 0..k-1 already resolved, and the remaining unresolved a/b chunks (b pre-inverted if sub).
- Stage 0 capture: b' = sub ? ~b : b; c0 = sub ? 1 : cin.
- Each stage computes chunk k with generate/propagate lookahead: chunk sum and chunk carry-out, which feeds stage k+1.
- Advance rule: stage k loads when !v[k] || stage k moves forward. The last stage moves on out_ready. in_ready = !v[0] || stage 0 advances. Bubbles collapse, so there is no global stall.
- Latency: STAGES cycles from input handshake to out_valid, with out_ready held at 1. Throughput is 1 beat/cycle. The block holds at most STAGES beats in flight.
- Order: strictly FIFO; no reordering.
- ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), evaluated in the last stage from the MSB bits, which are carried along the pipeline.
- cout = carry out of chunk STAGES-1.
- STAGES=1: purely registered single-stage CLA, with latency 1.
- Simultaneous input and output handshake when full: both occur, and occupancy is unchanged.
- Arithmetic is modulo 2^WIDTH; there is no exception other than ovf.

Optional Feature:
Macro CLA_ADDER_SATURATE_EN.
- Defined: when ovf=1, sum is clamped to the signed limit. If a[MSB]=0, sum = 0 followed by WIDTH-1 ones (max positive). If a[MSB]=1, sum = 1 followed by WIDTH-1 zeros (min negative). ovf and cout still report the raw, unclamped condition. The clamp is applied in the last stage, with no extra latency.
- Not defined: the result wraps modulo 2^WIDTH, and no saturation logic is present.

Test Plan:
1. WIDTH=64, STAGES=4, out_ready=1. Input a=0xFFFFFFFFFFFFFFFF, b=0x1, cin=0, sub=0 -> after 4 cycles: sum=0x0, cout=1, ovf=0.
2. Input a=5, b=7, sub=1 -> sum=0xFFFFFFFFFFFFFFFE, cout=0 (borrow), ovf=0. Input a=7, b=5, sub=1 -> sum=2, cout=1.
3. Input a=0x7FFFFFFFFFFFFFFF, b=1, sub=0 -> sum=0x8000000000000000, ovf=1. With CLA_ADDER_SATURATE_EN: sum=0x7FFFFFFFFFFFFFFF, ovf=1.
4. Stream 16 beats a=i, b=i*3, with in_valid held high; hold out_ready=0 for cycles 6..15 -> in_ready drops once 4 beats are held. All 16 results (sum=4i) arrive in order, with none lost or duplicated.
5. Assert rst_n=0 while 3 beats are in flight -> out_valid=0 immediately. After release, no stale beat appears, and the first new beat has latency 4.
6. STAGES=1, WIDTH=16: a=0x8000, b=0x8000 -> next cycle: sum=0x0000, cout=1, ovf=1.
